br_cmp_arbiter: RTL and testbench

- Shares one branch comparator (beq/bne/blt/bge/bltu/bgeu) between NREQ requesters, e.g. an early-resolve decode path and the execute path.
- Round-robin arbitration, one accept per cycle, registered result with requester ID and tag.
- Single-entry output register with valid/ready backpressure.

---
 rtl/br_cmp_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_br_cmp_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_cmp_arbiter.sv
// br_cmp_arbiter: shares one branch comparator between NREQ requesters.
// Round-robin arbitration accepts at most one request per cycle. The outcome
// is held in a single-entry result register with valid/ready backpressure.
//
// Optional build macro: BR_CMP_ARBITER_ILLEGAL_EN adds rsp_illegal, which
// flags reserved funct3 encodings (3'b010, 3'b011).
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   req_valid    [NREQ]        requester i has a compare pending
//   req_ready    [NREQ]        one-hot grant, request accepted at this edge
//   req_cmpop    [NREQ*3]      branch funct3 per requester, requester 0 in LSBs
//   req_a        [NREQ*WIDTH]  operand a per requester
//   req_b        [NREQ*WIDTH]  operand b per requester
//   req_tag      [NREQ*TAG_W]  opaque tag per requester
//   rsp_valid    result register holds a result
//   rsp_ready    consumer takes the result this cycle
//   rsp_id       [ID_W]        index of the requester that produced the result
//   rsp_tag      [TAG_W]       tag of that request
//   rsp_br_en    comparison outcome
//   rsp_illegal  (macro only) reserved funct3 was granted
module br_cmp_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*3-1:0]     req_cmpop,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  rsp_br_en
`ifdef BR_CMP_ARBITER_ILLEGAL_EN
  ,
  output logic                  rsp_illegal
`endif
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              load;
  logic              slot_free;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_next;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_id;
  logic              found;
  logic [2:0]        op_sel;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;
  logic [TAG_W-1:0]  tag_sel;
  logic              br_en_c;

  assign rsp_valid = (state == FULL);

  // A new result may be written when the register is empty or being drained.
  assign slot_free = !rst && (!rsp_valid || rsp_ready);
  assign req_ready = grant;

  // Round-robin search: first pass covers [ptr, NREQ), second wraps to [0, ptr).
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    if (slot_free) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i >= 32'(ptr))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grant_id = ID_W'(i);
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i < 32'(ptr))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grant_id = ID_W'(i);
        end
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_comb begin
    ptr_next = ptr;
    if (found) begin
      if (32'(grant_id) == NREQ - 1) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_id + ID_W'(1);
      end
    end
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    op_sel  = '0;
    a_sel   = '0;
    b_sel   = '0;
    tag_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        op_sel  = req_cmpop[i*3 +: 3];
        a_sel   = req_a[i*WIDTH +: WIDTH];
        b_sel   = req_b[i*WIDTH +: WIDTH];
        tag_sel = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Shared comparator; reserved encodings resolve to not-taken.
  always_comb begin
    br_en_c = 1'b0;
    case (op_sel)
      F3_BEQ:  br_en_c = (a_sel == b_sel);
      F3_BNE:  br_en_c = (a_sel != b_sel);
      F3_BLT:  br_en_c = ($signed(a_sel) <  $signed(b_sel));
      F3_BGE:  br_en_c = ($signed(a_sel) >= $signed(b_sel));
      F3_BLTU: br_en_c = (a_sel <  b_sel);
      F3_BGEU: br_en_c = (a_sel >= b_sel);
      default: br_en_c = 1'b0;
    endcase
  end

  // Result register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next state: a grant always loads; a drain without a grant empties.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      EMPTY: begin
        if (found) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (rsp_ready) begin
          if (found) begin
            load = 1'b1;
          end else begin
            state_next = EMPTY;
          end
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Result payload; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id    <= '0;
      rsp_tag   <= '0;
      rsp_br_en <= 1'b0;
    end else if (load) begin
      rsp_id    <= grant_id;
      rsp_tag   <= tag_sel;
      rsp_br_en <= br_en_c;
    end
  end

`ifdef BR_CMP_ARBITER_ILLEGAL_EN
  logic illegal_c;

  assign illegal_c = (op_sel == 3'b010) || (op_sel == 3'b011);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_illegal <= 1'b0;
    end else if (load) begin
      rsp_illegal <= illegal_c;
    end
  end
`endif

endmodule

// File: tb/tb_br_cmp_arbiter.sv
// Directed bench for br_cmp_arbiter with an independent arbitration model and
// an expected-result queue compared against the result register.
module tb_br_cmp_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int TAG_W = 4;
  localparam int ID_W  = 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
    logic             br;
    logic             ill;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*3-1:0]     req_cmpop;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  rsp_br_en;
`ifdef BR_CMP_ARBITER_ILLEGAL_EN
  logic                  rsp_illegal;
`endif

  logic [2:0]       op  [NREQ];
  logic [WIDTH-1:0] a   [NREQ];
  logic [WIDTH-1:0] b   [NREQ];
  logic [TAG_W-1:0] tag [NREQ];

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_full = 1'b0;
  int   m_ptr  = 0;
  bit   renew_mode = 1'b0;
  bit   ovr = 1'b0;
  bit   ovr_br = 1'b0;

  logic [WIDTH-1:0] vals [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [2:0]       ops  [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};

  br_cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmpop (req_cmpop),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_br_en (rsp_br_en)
`ifdef BR_CMP_ARBITER_ILLEGAL_EN
    ,
    .rsp_illegal (rsp_illegal)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_cmpop[i*3 +: 3]         = op[i];
      req_a[i*WIDTH +: WIDTH]     = a[i];
      req_b[i*WIDTH +: WIDTH]     = b[i];
      req_tag[i*TAG_W +: TAG_W]   = tag[i];
    end
  end

  function automatic logic ref_br(input logic [2:0] f, input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y);
    case (f)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return $signed(x) <  $signed(y);
      3'b101:  return $signed(x) >= $signed(y);
      3'b110:  return x <  y;
      3'b111:  return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic renew(input int k);
    op[k]  = ops[$urandom_range(0, 6)];
    a[k]   = vals[$urandom_range(0, 4)];
    b[k]   = vals[$urandom_range(0, 4)];
    tag[k] = TAG_W'($urandom_range(0, 15));
  endtask

  // One clock: check grant and result against the model at negedge, then advance.
  task automatic step();
    logic [NREQ-1:0] g;
    exp_t e;
    int   gk;
    bit   fnd;
    @(negedge clk);
    g   = '0;
    fnd = 1'b0;
    gk  = 0;
    if (!rst && (!m_full || rsp_ready)) begin
      for (int o = 0; o < NREQ; o++) begin
        int k;
        k = (m_ptr + o) % NREQ;
        if (!fnd && req_valid[k]) begin
          fnd   = 1'b1;
          g[k]  = 1'b1;
          gk    = k;
        end
      end
    end
    check("req_ready", 64'(req_ready), 64'(g));
    check("rsp_valid", 64'(rsp_valid), 64'(m_full));
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        e = q[0];
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        check("rsp_br_en", 64'(rsp_br_en), 64'(e.br));
`ifdef BR_CMP_ARBITER_ILLEGAL_EN
        check("rsp_illegal", 64'(rsp_illegal), 64'(e.ill));
`endif
        if (rsp_ready) void'(q.pop_front());
      end
    end
    if (fnd) begin
      e.id  = ID_W'(gk);
      e.tag = tag[gk];
      e.br  = ovr ? ovr_br : ref_br(op[gk], a[gk], b[gk]);
      e.ill = (op[gk] == 3'b010) || (op[gk] == 3'b011);
      q.push_back(e);
    end
    if (rst) begin
      m_full = 1'b0;
      m_ptr  = 0;
      q.delete();
    end else if (fnd) begin
      m_full = 1'b1;
      m_ptr  = (gk + 1) % NREQ;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    if (fnd) begin
      if (renew_mode) renew(gk);
      else req_valid[gk] = 1'b0;
    end
  endtask

  initial begin
    logic [2:0]       t_op [12];
    logic [WIDTH-1:0] t_a  [12];
    logic [WIDTH-1:0] t_b  [12];
    logic             t_br [12];

    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) renew(i);
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    check("reset_rsp_tag", 64'(rsp_tag), 64'(0));
    check("reset_rsp_br_en", 64'(rsp_br_en), 64'(0));
    rst = 1'b0;

    // Single request: signed blt taken, then unsigned bltu not taken.
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    op[0] = 3'b100; a[0] = 32'hFFFF_FFFF; b[0] = 32'h1; tag[0] = 4'd5;
    ovr = 1'b1; ovr_br = 1'b1;
    step();
    req_valid[0] = 1'b1; op[0] = 3'b110; tag[0] = 4'd6; ovr_br = 1'b0;
    step();
    step();
    ovr = 1'b0;

    // Both requesters continuously valid: strict rotation, one result per cycle.
    renew_mode = 1'b1;
    req_valid  = 2'b11;
    repeat (8) step();

    // Backpressure with both requesting, then release.
    rsp_ready = 1'b0;
    repeat (4) step();
    rsp_ready = 1'b1;
    repeat (3) step();

    // Op table on requester 1 alone.
    renew_mode = 1'b0;
    req_valid  = 2'b00;
    step();
    t_op = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111,
             3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    t_br = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 12; t++) begin
      t_a[t] = (t < 6) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      t_b[t] = 32'h8000_0000;
    end
    ovr = 1'b1;
    for (int t = 0; t < 12; t++) begin
      op[1] = t_op[t]; a[1] = t_a[t]; b[1] = t_b[t]; tag[1] = TAG_W'(t);
      ovr_br = t_br[t];
      req_valid[1] = 1'b1;
      step();
    end

    // Reserved encodings resolve to not-taken.
    ovr_br = 1'b0;
    op[0] = 3'b010; a[0] = 32'h3; b[0] = 32'h3; tag[0] = 4'hA; req_valid[0] = 1'b1;
    step();
    op[1] = 3'b011; a[1] = 32'h0; b[1] = 32'h1; tag[1] = 4'hB; req_valid[1] = 1'b1;
    step();
    ovr = 1'b0;
    step();

    // Reset while holding a result with both requesting.
    renew_mode = 1'b1;
    req_valid  = 2'b11;
    step();
    rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) step();

    // Drain.
    renew_mode = 1'b0;
    req_valid  = 2'b00;
    repeat (3) step();
    check("queue_empty", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
